// File: rtl/proc8085_pkg.sv
// proc8085_pkg: opcodes, register codes, ALU ops and the IF/EX bundle.
// SIGN_PARITY_EN adds the JP/JM opcodes to the jump set.
package proc8085_pkg;

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_HLT = 8'h76;
   localparam logic [7:0] OP_JMP = 8'hC3;
   localparam logic [7:0] OP_JNZ = 8'hC2;
   localparam logic [7:0] OP_JZ  = 8'hCA;
   localparam logic [7:0] OP_JNC = 8'hD2;
   localparam logic [7:0] OP_JC  = 8'hDA;
   localparam logic [7:0] OP_JP  = 8'hF2;
   localparam logic [7:0] OP_JM  = 8'hFA;

   localparam logic [2:0] REG_B = 3'd0;
   localparam logic [2:0] REG_C = 3'd1;
   localparam logic [2:0] REG_D = 3'd2;
   localparam logic [2:0] REG_E = 3'd3;
   localparam logic [2:0] REG_H = 3'd4;
   localparam logic [2:0] REG_L = 3'd5;
   localparam logic [2:0] REG_M = 3'd6;
   localparam logic [2:0] REG_A = 3'd7;
   localparam int         A_IDX = 6;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_ANA, ALU_XRA,
      ALU_ORA, ALU_INR, ALU_DCR, ALU_PASS
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [7:0]  opcode;
      logic [7:0]  imm8;
      logic [15:0] imm16;
   } if_ex_t;

   function automatic logic is_jump_op(input logic [7:0] op);
      logic j;
      j = op inside {OP_JMP, OP_JNZ, OP_JZ, OP_JNC, OP_JC};
`ifdef SIGN_PARITY_EN
      j = j || (op inside {OP_JP, OP_JM});
`endif
      return j;
   endfunction

   function automatic logic [1:0] instr_len(input logic [7:0] op);
      if (op[7:6] == 2'b00 && op[2:0] == 3'b110) return 2'd2;
      if (is_jump_op(op)) return 2'd3;
      return 2'd1;
   endfunction

   // A lives at index 6 because code 6 (M) has no storage.
   function automatic logic [2:0] reg_idx(input logic [2:0] code);
      return (code == REG_A) ? 3'(A_IDX) : code;
   endfunction

endpackage

// File: rtl/processor_8085_pipe_alu.sv
// alu_8085: combinational 8-bit ALU for the 8085 subset.
// cy is carry for ADD and borrow for SUB; logic ops clear it.
module alu_8085
   import proc8085_pkg::*;
(
   input  alu_op_e    op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic       cy,
   output logic       z
);

   logic [8:0] wide;

   // Compute result and carry/borrow for the selected operation
   always_comb begin
      wide   = '0;
      result = b;
      cy     = 1'b0;
      case (op)
         ALU_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[7:0];
            cy     = wide[8];
         end
         ALU_SUB: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[7:0];
            cy     = wide[8];
         end
         ALU_ANA: result = a & b;
         ALU_XRA: result = a ^ b;
         ALU_ORA: result = a | b;
         ALU_INR: result = a + 8'd1;
         ALU_DCR: result = a - 8'd1;
         default: result = b;
      endcase
      z = (result == 8'h00);
   end

endmodule

// File: rtl/processor_8085_pipe.sv
// processor_8085_pipe: 2-stage IF->EX 8085 subset core with internal ROM.
// SIGN_PARITY_EN adds s/p flag outputs and the JP/JM jumps.
module processor_8085_pipe
   import proc8085_pkg::*;
#(
   parameter int PROG_DEPTH = 256,
   parameter     PROG_FILE  = "prog.hex"
) (
   input  logic        clk,
   input  logic        rst,
   output logic        cy,
   output logic        z,
`ifdef SIGN_PARITY_EN
   output logic        s,
   output logic        p,
`endif
   output logic [7:0]  acc_out,
   output logic [15:0] pc_out,
   output logic        stall_jump,
   output logic        halted
);

   localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

   // Program image is preloaded by the loading flow from PROG_FILE.
   logic [7:0] rom [PROG_DEPTH];
   logic       unused_prog_file;
   assign unused_prog_file = ^PROG_FILE;

   logic [15:0] pc_q, pc_d;
   if_ex_t      ifex_q, ifex_d;
   logic [7:0]  regfile_q [7];
   logic [7:0]  regfile_d [7];
   logic        cy_q, cy_d, z_q, z_d;
   logic        stall_q, stall_d, halt_q, halt_d;
`ifdef SIGN_PARITY_EN
   logic        s_q, s_d, p_q, p_d;
`endif

   logic [7:0] op_f, b1_f, b2_f;
   logic [1:0] len_f;
   logic [7:0] op_x;
   logic [2:0] dst, src, rd, rs;
   logic       is_hlt, is_mov, is_mvi, is_inr, is_dcr, is_alu, is_jmp;
   logic       hlt_ex, jump_taken;
   alu_op_e    alu_op;
   logic [7:0] alu_a, alu_b, alu_res;
   logic       alu_cy, alu_z;

   function automatic logic [7:0] rom_rd(input logic [15:0] addr);
      if (32'(addr) < PROG_DEPTH) return rom[addr[AW-1:0]];
      return OP_NOP;
   endfunction

   // IF: read three bytes at pc and size the instruction
   always_comb begin
      op_f  = rom_rd(pc_q);
      b1_f  = rom_rd(pc_q + 16'd1);
      b2_f  = rom_rd(pc_q + 16'd2);
      len_f = instr_len(op_f);
   end

   // EX decode: classify the latched opcode and steer the ALU
   always_comb begin
      op_x   = ifex_q.opcode;
      dst    = op_x[5:3];
      src    = op_x[2:0];
      rd     = reg_idx(dst);
      rs     = reg_idx(src);
      is_hlt = ifex_q.valid && op_x == OP_HLT;
      is_mov = ifex_q.valid && op_x[7:6] == 2'b01 && op_x != OP_HLT
               && dst != REG_M && src != REG_M;
      is_mvi = ifex_q.valid && op_x[7:6] == 2'b00 && src == 3'b110
               && dst != REG_M;
      is_inr = ifex_q.valid && op_x[7:6] == 2'b00 && src == 3'b100
               && dst != REG_M;
      is_dcr = ifex_q.valid && op_x[7:6] == 2'b00 && src == 3'b101
               && dst != REG_M;
      is_alu = ifex_q.valid && op_x[7:6] == 2'b10 && src != REG_M
               && dst != 3'b001 && dst != 3'b011;
      is_jmp = ifex_q.valid && is_jump_op(op_x);
      alu_op = ALU_PASS;
      alu_a  = regfile_q[A_IDX];
      alu_b  = regfile_q[rs];
      if (is_inr || is_dcr) begin
         alu_op = is_inr ? ALU_INR : ALU_DCR;
         alu_a  = regfile_q[rd];
      end else if (is_alu) begin
         case (dst)
            3'b000:         alu_op = ALU_ADD;
            3'b010, 3'b111: alu_op = ALU_SUB;
            3'b100:         alu_op = ALU_ANA;
            3'b101:         alu_op = ALU_XRA;
            3'b110:         alu_op = ALU_ORA;
            default:        alu_op = ALU_PASS;
         endcase
      end
   end

   alu_8085 u_alu (
      .op     (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .cy     (alu_cy),
      .z      (alu_z)
   );

   // EX writeback: registers, flags, jump and halt resolution
   always_comb begin
      regfile_d  = regfile_q;
      cy_d       = cy_q;
      z_d        = z_q;
`ifdef SIGN_PARITY_EN
      s_d        = s_q;
      p_d        = p_q;
`endif
      hlt_ex     = 1'b0;
      jump_taken = 1'b0;
      unique case (1'b1)
         is_hlt: hlt_ex = 1'b1;
         is_mov: regfile_d[rd] = regfile_q[rs];
         is_mvi: regfile_d[rd] = ifex_q.imm8;
         is_inr, is_dcr: begin
            regfile_d[rd] = alu_res;
            z_d           = alu_z;
`ifdef SIGN_PARITY_EN
            s_d           = alu_res[7];
            p_d           = ~^alu_res;
`endif
         end
         is_alu: begin
            if (dst != 3'b111) regfile_d[A_IDX] = alu_res;
            cy_d = alu_cy;
            z_d  = alu_z;
`ifdef SIGN_PARITY_EN
            s_d  = alu_res[7];
            p_d  = ~^alu_res;
`endif
         end
         is_jmp: begin
            case (op_x)
               OP_JMP:  jump_taken = 1'b1;
               OP_JNZ:  jump_taken = !z_q;
               OP_JZ:   jump_taken = z_q;
               OP_JNC:  jump_taken = !cy_q;
               OP_JC:   jump_taken = cy_q;
`ifdef SIGN_PARITY_EN
               OP_JP:   jump_taken = !s_q;
               OP_JM:   jump_taken = s_q;
`endif
               default: jump_taken = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   // Next PC and IF/EX: halt freezes, taken jump squashes the fetch
   always_comb begin
      pc_d    = pc_q;
      ifex_d  = '0;
      stall_d = 1'b0;
      halt_d  = halt_q;
      if (halt_q) begin
         halt_d = 1'b1;
      end else if (hlt_ex) begin
         halt_d = 1'b1;
      end else if (jump_taken) begin
         pc_d    = ifex_q.imm16;
         stall_d = 1'b1;
      end else begin
         pc_d          = pc_q + 16'(len_f);
         ifex_d.valid  = 1'b1;
         ifex_d.opcode = op_f;
         ifex_d.imm8   = b1_f;
         ifex_d.imm16  = {b2_f, b1_f};
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= '0;
         ifex_q    <= '0;
         regfile_q <= '{default: 8'h00};
         cy_q      <= 1'b0;
         z_q       <= 1'b0;
         stall_q   <= 1'b0;
         halt_q    <= 1'b0;
`ifdef SIGN_PARITY_EN
         s_q       <= 1'b0;
         p_q       <= 1'b0;
`endif
      end else begin
         pc_q      <= pc_d;
         ifex_q    <= ifex_d;
         regfile_q <= regfile_d;
         cy_q      <= cy_d;
         z_q       <= z_d;
         stall_q   <= stall_d;
         halt_q    <= halt_d;
`ifdef SIGN_PARITY_EN
         s_q       <= s_d;
         p_q       <= p_d;
`endif
      end
   end

   assign cy         = cy_q;
   assign z          = z_q;
`ifdef SIGN_PARITY_EN
   assign s          = s_q;
   assign p          = p_q;
`endif
   assign acc_out    = regfile_q[A_IDX];
   assign pc_out     = pc_q;
   assign stall_jump = stall_q;
   assign halted     = halt_q;

endmodule

// File: tb/tb_processor_8085_pipe.sv
// tb_processor_8085_pipe: directed programs with hand-computed results.
// ROM images are written into the DUT array while reset is held.
module tb_processor_8085_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cy, z;
`ifdef SIGN_PARITY_EN
   logic        s, p;
`endif
   logic [7:0]  acc_out;
   logic [15:0] pc_out;
   logic        stall_jump, halted;

   int total = 0;
   int bad   = 0;
   logic [7:0] prog[$];

   logic [15:0] exp_pc [12] = '{16'd2, 16'd3, 16'd6, 16'd2, 16'd3,
      16'd6, 16'd2, 16'd3, 16'd6, 16'd7, 16'd7, 16'd7};
   logic [15:0] exp_st [12] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd0,
      16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

   processor_8085_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .cy         (cy),
      .z          (z),
`ifdef SIGN_PARITY_EN
      .s          (s),
      .p          (p),
`endif
      .acc_out    (acc_out),
      .pc_out     (pc_out),
      .stall_jump (stall_jump),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start();
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.rom[i] = 8'h00;
      for (int i = 0; i < prog.size(); i++) dut.rom[i] = prog[i];
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // MVI A,05; MVI B,03; ADD B
      prog = '{8'h3E, 8'h05, 8'h06, 8'h03, 8'h80};
      start();
      cycles(4);
      chk("add_acc", 16'(acc_out), 16'h08);
      chk("add_cy", 16'(cy), 16'd0);
      chk("add_z", 16'(z), 16'd0);
      chk("add_regb", 16'(dut.regfile_q[0]), 16'h03);
      chk("add_pc", pc_out, 16'd6);

      // MVI A,FF; MVI C,01; ADD C; INR C
      prog = '{8'h3E, 8'hFF, 8'h0E, 8'h01, 8'h81, 8'h0C};
      start();
      cycles(4);
      chk("ovf_acc", 16'(acc_out), 16'h00);
      chk("ovf_cy", 16'(cy), 16'd1);
      chk("ovf_z", 16'(z), 16'd1);
      cycles(1);
      chk("inr_c", 16'(dut.regfile_q[1]), 16'h02);
      chk("inr_cy", 16'(cy), 16'd1);
      chk("inr_z", 16'(z), 16'd0);

      // MVI A,10; MVI B,20; CMP B; SUB B
      prog = '{8'h3E, 8'h10, 8'h06, 8'h20, 8'hB8, 8'h90};
      start();
      cycles(4);
      chk("cmp_cy", 16'(cy), 16'd1);
      chk("cmp_z", 16'(z), 16'd0);
      chk("cmp_acc", 16'(acc_out), 16'h10);
      cycles(1);
      chk("sub_acc", 16'(acc_out), 16'hF0);
      chk("sub_cy", 16'(cy), 16'd1);
      chk("sub_z", 16'(z), 16'd0);

      // MVI B,3; DCR B; JNZ 0002; HLT
      prog = '{8'h06, 8'h03, 8'h05, 8'hC2, 8'h02, 8'h00, 8'h76};
      start();
      for (int k = 0; k < 12; k++) begin
         cycles(1);
         chk($sformatf("loop_pc%0d", k + 1), pc_out, exp_pc[k]);
         chk($sformatf("loop_stall%0d", k + 1), 16'(stall_jump), exp_st[k]);
         if (k == 8) begin
            chk("loop_b", 16'(dut.regfile_q[0]), 16'h00);
            chk("loop_z", 16'(z), 16'd1);
         end
      end
      chk("loop_halt", 16'(halted), 16'd1);

      // asynchronous reset in the middle of a halted run
      #2 rst = 1'b1;
      #1;
      chk("rst_pc", pc_out, 16'd0);
      chk("rst_acc", 16'(acc_out), 16'h00);
      chk("rst_cy", 16'(cy), 16'd0);
      chk("rst_z", 16'(z), 16'd0);
      chk("rst_halt", 16'(halted), 16'd0);
      chk("rst_stall", 16'(stall_jump), 16'd0);
      for (int r = 0; r < 7; r++)
         chk($sformatf("rst_reg%0d", r), 16'(dut.regfile_q[r]), 16'h00);

      // HLT; MVI A,55
      prog = '{8'h76, 8'h3E, 8'h55};
      start();
      cycles(1);
      chk("hlt_pre", 16'(halted), 16'd0);
      chk("hlt_pc1", pc_out, 16'd1);
      cycles(1);
      chk("hlt_set", 16'(halted), 16'd1);
      for (int k = 0; k < 20; k++) begin
         cycles(1);
         chk("hlt_pc", pc_out, 16'd1);
         chk("hlt_acc", 16'(acc_out), 16'h00);
         chk("hlt_flag", 16'(halted), 16'd1);
      end

      // JMP 1234: target lies beyond the ROM and reads as NOP
      prog = '{8'hC3, 8'h34, 8'h12};
      start();
      cycles(1);
      chk("jmp_pc1", pc_out, 16'd3);
      chk("jmp_st1", 16'(stall_jump), 16'd0);
      cycles(1);
      chk("jmp_pc2", pc_out, 16'h1234);
      chk("jmp_st2", 16'(stall_jump), 16'd1);
      cycles(1);
      chk("jmp_pc3", pc_out, 16'h1235);
      chk("jmp_st3", 16'(stall_jump), 16'd0);

      // JMP FFFF: the following NOP fetch wraps pc to 0
      prog = '{8'hC3, 8'hFF, 8'hFF};
      start();
      cycles(2);
      chk("wrap_pc1", pc_out, 16'hFFFF);
      cycles(1);
      chk("wrap_pc2", pc_out, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/processor_8085_pipe.md
Name: processor_8085_pipe

Overview:
- 2-stage pipelined (IF -> EX) core for an Intel 8085 instruction subset, using real 8085 opcodes.
- Contains an internal program ROM, a 7-entry 8-bit register file (regfile_8085), carry/zero flags and a 16-bit PC.
- Stand-alone top-level compute block. Flags, accumulator, PC and jump-stall status are exported for observation.

Parameters:
- PROG_DEPTH, 256: program ROM depth in bytes; addresses at or above PROG_DEPTH read 0x00 (NOP).
- PROG_FILE, "prog.hex": $readmemh image for the ROM.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cy  output  1  carry flag (registered)
- z  output  1  zero flag (registered)
- acc_out  output  8  accumulator (regfile_8085[6])
- pc_out  output  16  fetch PC
- stall_jump  output  1  high during the bubble cycle after a taken jump
- halted  output  1  HLT executed

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - pc=0; all regfile_8085 entries=0; cy=0; z=0.
  - IF/EX register holds a bubble (valid=0); stall_jump=0; halted=0.
- Register codes: B=0, C=1, D=2, E=3, H=4, L=5, A=7. A is stored at index 6. Code 6 (M, memory) is unsupported: any instruction using it executes as NOP.
- IF stage, combinational:
  - Reads bytes rom[pc], rom[pc+1], rom[pc+2] and decodes the length: 1 byte, 2 bytes (MVI) or 3 bytes (jumps).
  - On each clock edge, latches opcode and operands into IF/EX with valid=1, then pc <= pc + length.
- EX stage: executes the IF/EX instruction. Register and flag writeback happen on the same edge. Operands are read in EX, so no data hazards exist.
- Latency: the first instruction fetches in cycle 1 after reset release and writes back at the end of cycle 2. Throughput is 1 instruction/cycle.
- Supported instructions:
  - NOP 00
  - MOV d,s 01dddsss (excluding 76)
  - MVI d,imm 00ddd110
  - INR 00ddd100; DCR 00ddd101
  - ADD 10000sss; SUB 10010sss; ANA 10100sss; XRA 10101sss; ORA 10110sss; CMP 10111sss
  - JMP C3; JNZ C2; JZ CA; JNC D2; JC DA (little-endian 16-bit target)
  - HLT 76
  - All other opcodes execute as NOP.
- Flag rules:
  - ADD: cy = carry out of the 9-bit sum; z = (result==0).
  - SUB/CMP: cy = borrow (A < operand); z = (result==0). CMP does not write A.
  - ANA/XRA/ORA: cy=0; z updated.
  - INR/DCR: wrap modulo 256; update z; cy unchanged.
  - MOV/MVI/jumps: flags unchanged.
- Jump resolution in EX, using the current flags:
  - Taken: pc <= target. The instruction fetched in the same cycle is squashed (IF/EX valid=0 next cycle), and stall_jump=1 for exactly that bubble cycle.
  - Not taken: no penalty; stall_jump stays 0.
- HLT in EX:
  - halted=1; pc freezes; IF/EX is loaded with a bubble and stays a bubble.
  - Only rst exits the halted state.
- PC increment wraps modulo 2^16.
- A taken jump and a new fetch in the same cycle: the jump wins.

Optional Feature:
- Macro SIGN_PARITY_EN.
- Defined: adds outputs s (result[7]) and p (even parity of result). Both are updated by exactly the instructions that update z, and reset to 0. Adds JP F2 / JM FA conditional jumps, with the same penalty rules as the other jumps.
- Undefined: ports s and p are absent; F2 and FA execute as NOP.

Decomposition:
- Package proc8085_pkg: opcode constants, register-code constants (REG_B..REG_A, A_IDX=6), ALU-op enum, and the IF/EX struct (valid, opcode, imm8, imm16).
- One sub-module, alu_8085: combinational 8-bit ALU returning result, cy and z.

Test Plan:
- Reset mid-run with rst=1 -> pc_out=0, acc_out=0, cy=0, z=0, halted=0, all registers 0, asynchronously.
- MVI A,0x05; MVI B,0x03; ADD B -> acc_out=0x08, cy=0, z=0; regfile_8085[0]=0x03.
- MVI A,0xFF; MVI C,0x01; ADD C -> acc_out=0x00, cy=1, z=1. Then INR C -> C=0x02, cy still 1.
- Countdown loop: MVI B,3; DCR B; JNZ to the DCR -> B reaches 0, z=1. Two taken jumps each give one stall_jump pulse and pc_out reload. The final not-taken JNZ gives no pulse.
- MVI A,0x10; MVI B,0x20; CMP B -> cy=1, z=0, A stays 0x10. SUB B -> A=0xF0, cy=1.
- HLT followed by MVI A,0x55 -> halted=1, pc_out frozen, A unchanged for 20 cycles.
